bcd_calendar_counter: RTL and testbench

Parametrised BCD date/time counter: hundredths, seconds, minutes, hours, day, month and an N-digit year in one carry chain. Supports month-length-aware rollover, a field-set mode with per-field increment, and a year-wrap flag. It replaces the per-digit calendar counters, whose cross-digit terminal-count conditions were hand-written, in the clock/calendar display datapath.

---
 rtl/calendar_pkg.sv | 57 +++++
 rtl/bcd_digit_pair.sv | 30 +++
 rtl/bcd_calendar_counter.sv | 150 +++++++++++++++
 tb/tb_bcd_calendar_counter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calendar_pkg.sv
// Shared definitions for the BCD calendar counter: field select codes,
// BCD field limits, and the BCD increment and month-length helpers.
package calendar_pkg;

    typedef enum logic [2:0] {
        FIELD_CS    = 3'd0,
        FIELD_SEC   = 3'd1,
        FIELD_MIN   = 3'd2,
        FIELD_HOUR  = 3'd3,
        FIELD_DAY   = 3'd4,
        FIELD_MONTH = 3'd5,
        FIELD_YEAR  = 3'd6,
        FIELD_RSVD  = 3'd7
    } fieldSel_e;

    localparam logic [7:0] BCD_MAX_CS    = 8'h99;
    localparam logic [7:0] BCD_MAX_SEC   = 8'h59;
    localparam logic [7:0] BCD_MAX_MIN   = 8'h59;
    localparam logic [7:0] BCD_MAX_HOUR  = 8'h23;
    localparam logic [7:0] BCD_MAX_MONTH = 8'h12;
    localparam logic [7:0] BCD_ZERO      = 8'h00;
    localparam logic [7:0] BCD_ONE       = 8'h01;

    // Two-digit BCD increment that wraps to minVal once maxVal is reached.
    function automatic logic [7:0] bcdIncWrap(
        input logic [7:0] v,
        input logic [7:0] maxVal,
        input logic [7:0] minVal
    );
        if (v >= maxVal)
            return minVal;
        if (v[3:0] == 4'h9)
            return {v[7:4] + 4'h1, 4'h0};
        return {v[7:4], v[3:0] + 4'h1};
    endfunction

    function automatic logic [7:0] monthLen(
        input logic [7:0] month,
        input logic       leap
    );
        case (month)
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            8'h02:                      return leap ? 8'h29 : 8'h28;
            default:                    return 8'h31;
        endcase
    endfunction

    // Divisible by 4 using the two low BCD year digits; no century rule.
    function automatic logic isLeapYear(input logic [7:0] yy);
        logic [3:0] units;
        units = yy[3:0];
        if (!yy[4])
            return (units == 4'h0) || (units == 4'h4) || (units == 4'h8);
        return (units == 4'h2) || (units == 4'h6);
    endfunction

endpackage

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD field register with wrap from maxVal back to minVal.
// Ports: clk, rst (sync, active-high), incEn, maxVal, minVal, clamp, value, carry.
module bcd_digit_pair
    import calendar_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       incEn,
    input  logic [7:0] maxVal,
    input  logic [7:0] minVal,
    input  logic       clamp,
    output logic [7:0] value,
    output logic       carry
);

    // Carry out is asserted on the increment that wraps the field.
    assign carry = incEn && (value >= maxVal);

    // Clamp pulls an over-range value down to maxVal when the range
    // shrinks underneath it (day after a month or year change).
    always_ff @(posedge clk) begin
        if (rst)
            value <= minVal;
        else if (incEn)
            value <= bcdIncWrap(value, maxVal, minVal);
        else if (clamp && (value > maxVal))
            value <= maxVal;
    end

endmodule

// File: rtl/bcd_calendar_counter.sv
// BCD date/time counter: hundredths..month in 2-digit pairs plus N-digit year.
// Ports: clk, rst (sync, active-high), tick, run, set_mode, field_sel, inc,
//        hundredths, seconds, minutes, hours, day, month, year, year_wrap.
// Optional macro LEAP_YEAR_EN: 29-day February when low year digits divide by 4.
module bcd_calendar_counter
    import calendar_pkg::*;
#(
    parameter int                         YEAR_DIGITS = 4,
    parameter logic [4*YEAR_DIGITS-1:0]   RESET_YEAR  = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     run,
    input  logic                     set_mode,
    input  logic [2:0]               field_sel,
    input  logic                     inc,
    output logic [7:0]               hundredths,
    output logic [7:0]               seconds,
    output logic [7:0]               minutes,
    output logic [7:0]               hours,
    output logic [7:0]               day,
    output logic [7:0]               month,
    output logic [4*YEAR_DIGITS-1:0] year,
    output logic                     year_wrap
);

    logic countStep;
    logic setInc;
    logic csInc, secInc, minInc, hourInc, dayInc, monthInc, yearInc;
    logic csCarry, secCarry, minCarry, hourCarry, dayCarry, monthCarry;
    logic clampDay;
    logic leapCur, leapNew;
    logic [7:0] monthNew;
    logic [7:0] curLen, newLen, dayMax;

    logic [3:0]             yearDig [YEAR_DIGITS];
    logic [YEAR_DIGITS:0]   yCarry;

    assign countStep = tick && run && !set_mode;
    assign setInc    = set_mode && inc;

    // Set-mode increments are confined to their own field; carries from
    // the lower pairs only propagate on a real count step.
    assign csInc    = countStep ||
                      (setInc && field_sel == FIELD_CS);
    assign secInc   = (countStep && csCarry) ||
                      (setInc && field_sel == FIELD_SEC);
    assign minInc   = (countStep && secCarry) ||
                      (setInc && field_sel == FIELD_MIN);
    assign hourInc  = (countStep && minCarry) ||
                      (setInc && field_sel == FIELD_HOUR);
    assign dayInc   = (countStep && hourCarry) ||
                      (setInc && field_sel == FIELD_DAY);
    assign monthInc = (countStep && dayCarry) ||
                      (setInc && field_sel == FIELD_MONTH);
    assign yearInc  = (countStep && monthCarry) ||
                      (setInc && field_sel == FIELD_YEAR);

    // A set-mode month/year change may shorten the month under the day;
    // the day limit then switches to the length of the new month/year.
    assign clampDay = setInc &&
                      (field_sel == FIELD_MONTH || field_sel == FIELD_YEAR);
    assign monthNew = (setInc && field_sel == FIELD_MONTH) ?
                      bcdIncWrap(month, BCD_MAX_MONTH, BCD_ONE) : month;
    assign curLen   = monthLen(month, leapCur);
    assign newLen   = monthLen(monthNew, leapNew);
    assign dayMax   = clampDay ? newLen : curLen;

`ifdef LEAP_YEAR_EN
    logic [7:0] yearLow;
    logic [7:0] yearLowNext;

    if (YEAR_DIGITS == 1) begin : gLowOne
        assign yearLow     = {4'h0, yearDig[0]};
        assign yearLowNext = {4'h0,
                              (yearDig[0] == 4'h9) ? 4'h0 : yearDig[0] + 4'h1};
    end else begin : gLowTwo
        assign yearLow     = {yearDig[1], yearDig[0]};
        assign yearLowNext = bcdIncWrap(yearLow, 8'h99, 8'h00);
    end

    assign leapCur = isLeapYear(yearLow);
    assign leapNew = isLeapYear(
        (setInc && field_sel == FIELD_YEAR) ? yearLowNext : yearLow);
`else
    assign leapCur = 1'b0;
    assign leapNew = 1'b0;
`endif

    bcd_digit_pair uCs (
        .clk(clk), .rst(rst), .incEn(csInc),
        .maxVal(BCD_MAX_CS), .minVal(BCD_ZERO), .clamp(1'b0),
        .value(hundredths), .carry(csCarry)
    );

    bcd_digit_pair uSec (
        .clk(clk), .rst(rst), .incEn(secInc),
        .maxVal(BCD_MAX_SEC), .minVal(BCD_ZERO), .clamp(1'b0),
        .value(seconds), .carry(secCarry)
    );

    bcd_digit_pair uMin (
        .clk(clk), .rst(rst), .incEn(minInc),
        .maxVal(BCD_MAX_MIN), .minVal(BCD_ZERO), .clamp(1'b0),
        .value(minutes), .carry(minCarry)
    );

    bcd_digit_pair uHour (
        .clk(clk), .rst(rst), .incEn(hourInc),
        .maxVal(BCD_MAX_HOUR), .minVal(BCD_ZERO), .clamp(1'b0),
        .value(hours), .carry(hourCarry)
    );

    bcd_digit_pair uDay (
        .clk(clk), .rst(rst), .incEn(dayInc),
        .maxVal(dayMax), .minVal(BCD_ONE), .clamp(clampDay),
        .value(day), .carry(dayCarry)
    );

    bcd_digit_pair uMonth (
        .clk(clk), .rst(rst), .incEn(monthInc),
        .maxVal(BCD_MAX_MONTH), .minVal(BCD_ONE), .clamp(1'b0),
        .value(month), .carry(monthCarry)
    );

    // Year: ripple of single BCD digits, each carrying on 9->0.
    assign yCarry[0] = yearInc;

    for (genvar i = 0; i < YEAR_DIGITS; i++) begin : gYear
        assign yCarry[i+1]   = yCarry[i] && (yearDig[i] == 4'h9);
        assign year[4*i +: 4] = yearDig[i];

        always_ff @(posedge clk) begin
            if (rst)
                yearDig[i] <= RESET_YEAR[4*i +: 4];
            else if (yCarry[i])
                yearDig[i] <= (yearDig[i] == 4'h9) ? 4'h0 : yearDig[i] + 4'h1;
        end
    end

    // Carry out of the top digit means every digit was 9.
    always_ff @(posedge clk) begin
        if (rst)
            year_wrap <= 1'b0;
        else
            year_wrap <= yCarry[YEAR_DIGITS];
    end

endmodule

// File: tb/tb_bcd_calendar_counter.sv
// Self-checking bench for bcd_calendar_counter (YEAR_DIGITS=4, reset year 2024).
// Build with or without LEAP_YEAR_EN; February expectations follow the macro.
module tb_bcd_calendar_counter;

`ifdef LEAP_YEAR_EN
    localparam bit LEAP = 1'b1;
`else
    localparam bit LEAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        run = 1'b0;
    logic        set_mode = 1'b0;
    logic [2:0]  field_sel = 3'd0;
    logic        inc = 1'b0;
    logic [7:0]  hundredths, seconds, minutes, hours, day, month;
    logic [15:0] year;
    logic        year_wrap;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0]  cs;
        logic [7:0]  sec;
        logic [7:0]  min;
        logic [7:0]  hr;
        logic [7:0]  dy;
        logic [7:0]  mon;
        logic [15:0] yr;
        logic        wrap;
    } snap_t;

    typedef struct {
        string nm;
        snap_t exp;
    } sb_t;

    typedef struct {
        logic       t;
        logic       r;
        logic       s;
        logic [2:0] f;
        logic       i;
        snap_t      exp;
    } vec_t;

    sb_t  expQ[$];
    vec_t vecs[14];

    bcd_calendar_counter #(
        .YEAR_DIGITS(4),
        .RESET_YEAR (16'h2024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .run       (run),
        .set_mode  (set_mode),
        .field_sel (field_sel),
        .inc       (inc),
        .hundredths(hundredths),
        .seconds   (seconds),
        .minutes   (minutes),
        .hours     (hours),
        .day       (day),
        .month     (month),
        .year      (year),
        .year_wrap (year_wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic snap_t mk(
        input logic [7:0] cs, input logic [7:0] sec,
        input logic [7:0] mn, input logic [7:0] hr,
        input logic [7:0] dy, input logic [7:0] mon,
        input logic [15:0] yr, input logic wrap
    );
        snap_t s;
        s = {cs, sec, mn, hr, dy, mon, yr, wrap};
        return s;
    endfunction

    function automatic snap_t actual();
        snap_t s;
        s = {hundredths, seconds, minutes, hours, day, month, year, year_wrap};
        return s;
    endfunction

    task automatic compareFront();
        sb_t e;
        snap_t a;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("FAIL scoreboard: got empty queue required entry");
        end else begin
            e = expQ.pop_front();
            a = actual();
            if (a !== e.exp) begin
                failures++;
                $display("FAIL %s: got %h required %h", e.nm, a, e.exp);
            end
        end
    endtask

    // One clock with the given inputs; the expectation is queued with the
    // stimulus and retired just after the edge that produces it.
    task automatic drive(
        input string nm, input logic t, input logic r, input logic s,
        input logic [2:0] f, input logic i, input snap_t e
    );
        tick = t; run = r; set_mode = s; field_sel = f; inc = i;
        expQ.push_back('{nm, e});
        @(posedge clk); #1;
        tick = 1'b0; inc = 1'b0; set_mode = 1'b0; run = 1'b0;
        compareFront();
    endtask

    task automatic setField(input logic [2:0] f, input int n);
        for (int k = 0; k < n; k++) begin
            set_mode = 1'b1; field_sel = f; inc = 1'b1;
            @(posedge clk); #1;
            inc = 1'b0;
        end
        set_mode = 1'b0;
    endtask

    task automatic doReset();
        tick = 0; run = 0; set_mode = 0; inc = 0; field_sel = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Preset time to 23:59:59.99 (other fields untouched).
    task automatic presetLastTick();
        setField(3'd3, 23);
        setField(3'd2, 59);
        setField(3'd1, 59);
        setField(3'd0, 99);
    endtask

    initial begin
        snap_t rstSnap;
        rstSnap = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 16'h2024, 1'b0);

        vecs[0]  = '{1, 1, 0, 3'd0, 0, mk(8'h01, 0, 0, 0, 8'h01, 8'h01, 16'h2024, 0)};
        vecs[1]  = '{1, 0, 0, 3'd0, 0, mk(8'h01, 0, 0, 0, 8'h01, 8'h01, 16'h2024, 0)};
        vecs[2]  = '{1, 1, 1, 3'd0, 0, mk(8'h01, 0, 0, 0, 8'h01, 8'h01, 16'h2024, 0)};
        vecs[3]  = '{0, 0, 1, 3'd0, 1, mk(8'h02, 0, 0, 0, 8'h01, 8'h01, 16'h2024, 0)};
        vecs[4]  = '{0, 0, 0, 3'd0, 1, mk(8'h02, 0, 0, 0, 8'h01, 8'h01, 16'h2024, 0)};
        vecs[5]  = '{0, 0, 1, 3'd7, 1, mk(8'h02, 0, 0, 0, 8'h01, 8'h01, 16'h2024, 0)};
        vecs[6]  = '{0, 0, 1, 3'd1, 1, mk(8'h02, 8'h01, 0, 0, 8'h01, 8'h01, 16'h2024, 0)};
        vecs[7]  = '{0, 0, 1, 3'd2, 1, mk(8'h02, 8'h01, 8'h01, 0, 8'h01, 8'h01, 16'h2024, 0)};
        vecs[8]  = '{0, 0, 1, 3'd3, 1, mk(8'h02, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 16'h2024, 0)};
        vecs[9]  = '{0, 0, 1, 3'd4, 1, mk(8'h02, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 16'h2024, 0)};
        vecs[10] = '{0, 0, 1, 3'd5, 1, mk(8'h02, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 16'h2024, 0)};
        vecs[11] = '{0, 0, 1, 3'd6, 1, mk(8'h02, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 16'h2025, 0)};
        vecs[12] = '{1, 1, 0, 3'd0, 0, mk(8'h03, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 16'h2025, 0)};
        vecs[13] = '{1, 1, 1, 3'd0, 1, mk(8'h04, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 16'h2025, 0)};

        // Reset then idle.
        doReset();
        for (int k = 0; k < 3; k++)
            drive("reset_idle", 0, 0, 0, 3'd0, 0, rstSnap);

        // Table vectors from the reset state.
        for (int v = 0; v < 14; v++)
            drive($sformatf("vec%0d", v), vecs[v].t, vecs[v].r, vecs[v].s,
                  vecs[v].f, vecs[v].i, vecs[v].exp);

        // Month change clamps day; tick in same cycle is dropped.
        doReset();
        setField(3'd4, 30);
        drive("clamp_month", 1, 1, 1, 3'd5, 1,
              mk(0, 0, 0, 0, LEAP ? 8'h29 : 8'h28, 8'h02, 16'h2024, 0));
        drive("clamp_year", 0, 0, 1, 3'd6, 1,
              mk(0, 0, 0, 0, 8'h28, 8'h02, 16'h2025, 0));
        drive("set_day_wrap", 0, 0, 1, 3'd4, 1,
              mk(0, 0, 0, 0, 8'h01, 8'h02, 16'h2025, 0));
        for (int k = 0; k < 10; k++)
            drive("run_low", 1, 0, 0, 3'd0, 0,
                  mk(0, 0, 0, 0, 8'h01, 8'h02, 16'h2025, 0));

        // New year rollover.
        doReset();
        setField(3'd5, 11);
        setField(3'd4, 30);
        presetLastTick();
        drive("preset_nye", 0, 0, 0, 3'd0, 0,
              mk(8'h99, 8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 16'h2024, 0));
        drive("set_cs_nocarry", 0, 0, 1, 3'd0, 1,
              mk(8'h00, 8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 16'h2024, 0));
        setField(3'd0, 99);
        drive("nye_tick", 1, 1, 0, 3'd0, 0,
              mk(0, 0, 0, 0, 8'h01, 8'h01, 16'h2025, 0));
        drive("nye_hold", 0, 0, 0, 3'd0, 0,
              mk(0, 0, 0, 0, 8'h01, 8'h01, 16'h2025, 0));

        // February end in 2024.
        doReset();
        setField(3'd5, 1);
        setField(3'd4, 27);
        presetLastTick();
        drive("feb_2024", 1, 1, 0, 3'd0, 0,
              mk(0, 0, 0, 0, LEAP ? 8'h29 : 8'h01, LEAP ? 8'h02 : 8'h03,
                 16'h2024, 0));

        // Year wrap from 9999.
        doReset();
        setField(3'd6, 7975);
        setField(3'd5, 11);
        setField(3'd4, 30);
        presetLastTick();
        drive("preset_9999", 0, 0, 0, 3'd0, 0,
              mk(8'h99, 8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 16'h9999, 0));
        drive("wrap_tick", 1, 1, 0, 3'd0, 0,
              mk(0, 0, 0, 0, 8'h01, 8'h01, 16'h0000, 1));
        drive("wrap_clear", 0, 0, 0, 3'd0, 0,
              mk(0, 0, 0, 0, 8'h01, 8'h01, 16'h0000, 0));

        // February end in 2023 (never leap).
        setField(3'd6, 2023);
        setField(3'd5, 1);
        setField(3'd4, 27);
        presetLastTick();
        drive("feb_2023", 1, 1, 0, 3'd0, 0,
              mk(0, 0, 0, 0, 8'h01, 8'h03, 16'h2023, 0));

        // Reset wins over tick/set/inc in the same cycle.
        rst = 1'b1;
        drive("rst_priority", 1, 1, 1, 3'd0, 1, rstSnap);
        rst = 1'b0;
        drive("post_rst", 0, 0, 0, 3'd0, 0, rstSnap);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
